// File: rtl/uart_pkg.sv
// Shared definitions for the UART beacon/echo block: state encoding,
// byte width and the default beacon period.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int unsigned DEFAULT_PERIOD_CYCLES = 27_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with power-of-2 DEPTH, registered level and a combinational head.
// A push is accepted when not full, or when full and a pop happens in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [BYTE_W-1:0]      i_push_dat,
  input  logic                   i_pop,
  output logic [BYTE_W-1:0]      o_head_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full     = (r_level == FULL_LVL);
  assign o_empty    = (r_level == '0);
  assign w_pop_ok   = i_pop && !o_empty;
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_level    = r_level;

  // Storage needs no reset; only pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_beacon_echo.sv
// Sends MSG every PERIOD_CYCLES over a registered valid/ready tx port; with UART_BEACON_ECHO_EN
// defined, received bytes are queued and echoed between beacons (rx_data_ready = FIFO not full).
module uart_beacon_echo
  import uart_pkg::*;
#(
  parameter int                        MSG_LEN       = 21,
  parameter logic [MSG_LEN*BYTE_W-1:0] MSG           = {"Hello Tang Nano 20K", 8'h0D, 8'h0A},
  parameter int unsigned               PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int                        FIFO_DEPTH    = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          rx_data_valid,
  output logic                          rx_data_ready,
  output logic [BYTE_W-1:0]             tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          sending
);

  localparam logic [7:0]  LAST_K  = 8'(MSG_LEN - 1);
  localparam logic [31:0] CNT_MAX = 32'(PERIOD_CYCLES - 1);
  localparam int          LVL_W   = $clog2(FIFO_DEPTH) + 1;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_k;
  logic [7:0]                w_k_sel;
  logic [31:0]               r_cnt;
  logic [BYTE_W-1:0]         r_tx_dat;
  logic                      r_tx_vld;
  logic [BYTE_W-1:0]         w_msg_byte;
  logic [BYTE_W-1:0]         w_head_dat;
  logic [MSG_LEN*BYTE_W-1:0] w_msg_shift;
  logic                      w_xfer;
  logic                      w_last_xfer;
  logic                      w_expire;
  logic                      w_pop;
  logic                      w_empty;
  logic                      w_sending;

  assign w_xfer      = r_tx_vld && tx_data_ready;
  assign w_last_xfer = w_xfer && (r_k == LAST_K);
  // While a byte is up, the register loads the one after it on transfer.
  assign w_k_sel     = r_tx_vld ? r_k + 8'd1 : r_k;
  assign w_msg_shift = MSG << {w_k_sel, 3'b000};
  assign w_msg_byte  = w_msg_shift[MSG_LEN*BYTE_W-1 -: BYTE_W];

  assign tx_data       = r_tx_dat;
  assign tx_data_valid = r_tx_vld;
  assign sending       = w_sending;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_SEND;
      ST_SEND: if (w_last_xfer) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_expire) w_state_nxt = ST_SEND;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Exit to SEND only once any echo byte has drained, and never pop on that cycle.
  always_comb begin
    w_sending = (r_state == ST_SEND);
    w_expire  = (r_state == ST_WAIT) && !r_tx_vld && (r_cnt == CNT_MAX);
    w_pop     = (r_state == ST_WAIT) && !r_tx_vld && !w_empty && !w_expire;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx_dat <= '0;
      r_tx_vld <= 1'b0;
      r_k      <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_SEND: begin
          if (!r_tx_vld) begin
            r_tx_dat <= w_msg_byte;
            r_tx_vld <= 1'b1;
          end else if (w_last_xfer) begin
            r_tx_vld <= 1'b0;
            r_cnt    <= '0;
          end else if (w_xfer) begin
            r_tx_dat <= w_msg_byte;
            r_k      <= r_k + 8'd1;
          end
        end
        ST_WAIT: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 32'd1;
          end
          if (w_xfer) begin
            r_tx_vld <= 1'b0;
          end else if (w_pop) begin
            r_tx_dat <= w_head_dat;
            r_tx_vld <= 1'b1;
          end
          if (w_expire) begin
            r_k <= '0;
          end
        end
        default: r_k <= '0;
      endcase
    end
  end

`ifdef UART_BEACON_ECHO_EN
  logic             w_full;
  logic             w_push;
  logic             r_overflow;
  logic [LVL_W-1:0] w_level;

  assign w_push = rx_data_valid && !w_full;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .i_push     (w_push),
    .i_push_dat (rx_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_overflow <= 1'b0;
    end else if (rx_data_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign rx_data_ready = !w_full;
  assign fifo_level    = w_level;
  assign overflow      = r_overflow;
`else
  logic w_unused_rx;

  assign w_unused_rx   = ^{rx_data, rx_data_valid};
  assign w_empty       = 1'b1;
  assign w_head_dat    = '0;
  assign rx_data_ready = 1'b1;
  assign fifo_level    = '0;
  assign overflow      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_beacon_echo.sv
// Bench for uart_beacon_echo with a 3-byte "ABC" message, 10-clock period and 4-deep echo FIFO.
// Echo scenarios run only when UART_BEACON_ECHO_EN is defined for the build.
module tb_uart_beacon_echo;

  localparam int          MSG_LEN = 3;
  localparam logic [23:0] MSG     = "ABC";
  localparam int unsigned PERIOD  = 10;
  localparam int          DEPTH   = 4;
  localparam int          LW      = $clog2(DEPTH) + 1;

  logic          sys_clk       = 1'b0;
  logic          sys_rst_n     = 1'b1;
  logic [7:0]    rx_data       = 8'h00;
  logic          rx_data_valid = 1'b0;
  logic          tx_data_ready = 1'b0;
  logic          rx_data_ready;
  logic [7:0]    tx_data;
  logic          tx_data_valid;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          sending;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_msg [MSG_LEN] = '{8'h41, 8'h42, 8'h43};

  uart_beacon_echo #(
    .MSG_LEN       (MSG_LEN),
    .MSG           (MSG),
    .PERIOD_CYCLES (PERIOD),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .sending       (sending)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic hold_reset();
    sys_rst_n     = 1'b0;
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || sending !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx valid=%b data=%h sending=%b expected 0/00/0", tx_data_valid, tx_data, sending);
    end
    checks++;
    if (rx_data_ready !== 1'b1 || fifo_level !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx ready=%b level=%0d overflow=%b expected 1/0/0", rx_data_ready, fifo_level, overflow);
    end
    repeat (2) tick();
    checks++;
    if (tx_data_valid !== 1'b0 || sending !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold valid=%b sending=%b expected 0/0", tx_data_valid, sending);
    end
  endtask

  task automatic test_first_message();
    tx_data_ready = 1'b1;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    checks++;
    if (sending !== 1'b1 || tx_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL send_entry sending=%b valid=%b expected 1/0", sending, tx_data_valid);
    end
    for (int k = 0; k < MSG_LEN; k++) begin
      tick();
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[k]) begin
        errors++;
        $display("FAIL msg_byte%0d valid=%b data=%h expected 1/%h", k, tx_data_valid, tx_data, exp_msg[k]);
      end
    end
    tick();
    checks++;
    if (tx_data_valid !== 1'b0 || sending !== 1'b0) begin
      errors++;
      $display("FAIL msg_end valid=%b sending=%b expected 0/0", tx_data_valid, sending);
    end
  endtask

  // Continues from the final transfer of the first message.
  task automatic test_period();
    for (int i = 1; i < PERIOD; i++) begin
      tick();
      checks++;
      if (sending !== 1'b0 || tx_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL period_wait%0d sending=%b valid=%b expected 0/0", i, sending, tx_data_valid);
      end
    end
    tick();
    checks++;
    if (sending !== 1'b1) begin
      errors++;
      $display("FAIL period_send sending=%b expected 1", sending);
    end
    tick();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[0]) begin
      errors++;
      $display("FAIL period_first valid=%b data=%h expected 1/%h", tx_data_valid, tx_data, exp_msg[0]);
    end
  endtask

  // Continues with byte 0 of the second message presented.
  task automatic test_stall();
    tick();
    tx_data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[1]) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b data=%h expected 1/%h", i, tx_data_valid, tx_data, exp_msg[1]);
      end
    end
    tx_data_ready = 1'b1;
    tick();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[2]) begin
      errors++;
      $display("FAIL stall_next valid=%b data=%h expected 1/%h", tx_data_valid, tx_data, exp_msg[2]);
    end
    tick();
    checks++;
    if (tx_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end valid=%b expected 0", tx_data_valid);
    end
  endtask

  task automatic test_reset_mid_byte();
    hold_reset();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (2) tick();
    tx_data_ready = 1'b1;
    tick();
    tx_data_ready = 1'b0;
    tick();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[1]) begin
      errors++;
      $display("FAIL rstmid_pre valid=%b data=%h expected 1/%h", tx_data_valid, tx_data, exp_msg[1]);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || sending !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async valid=%b data=%h sending=%b expected 0/00/0", tx_data_valid, tx_data, sending);
    end
    tx_data_ready = 1'b1;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[0]) begin
      errors++;
      $display("FAIL rstmid_restart valid=%b data=%h expected 1/%h", tx_data_valid, tx_data, exp_msg[0]);
    end
  endtask

  // Random tx backpressure; the model tracks message position and the cycle of the last message byte.
  task automatic test_random_throttle();
    int         last_cyc;
    int         k;
    int         msgs;
    logic       prev_vld;
    logic       prev_rdy;
    logic [7:0] prev_dat;
    hold_reset();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    // Reset release behaves like a message end PERIOD-1 clocks before edge 0: SEND begins at edge 1.
    last_cyc = 1 - int'(PERIOD);
    k = 0;
    msgs = 0;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_dat = 8'h00;
    for (int e = 1; e <= 300; e++) begin
      tick();
      if (prev_vld && prev_rdy) begin
        checks++;
        if (prev_dat !== exp_msg[k]) begin
          errors++;
          $display("FAIL rnd_order edge=%0d got=%h expected=%h", e, prev_dat, exp_msg[k]);
        end
        k++;
        if (k == MSG_LEN) begin
          k = 0;
          last_cyc = e;
          msgs++;
          checks++;
          if (tx_data_valid !== 1'b0 || sending !== 1'b0) begin
            errors++;
            $display("FAIL rnd_msg_end edge=%0d valid=%b sending=%b expected 0/0", e, tx_data_valid, sending);
          end
        end else begin
          checks++;
          if (tx_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL rnd_no_bubble edge=%0d valid=%b expected 1", e, tx_data_valid);
          end
        end
      end else if (prev_vld) begin
        checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== prev_dat) begin
          errors++;
          $display("FAIL rnd_hold edge=%0d valid=%b data=%h expected 1/%h", e, tx_data_valid, tx_data, prev_dat);
        end
      end
      if (e > last_cyc && e < last_cyc + int'(PERIOD)) begin
        checks++;
        if (sending !== 1'b0 || tx_data_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_wait edge=%0d sending=%b valid=%b expected 0/0", e, sending, tx_data_valid);
        end
      end else if (e == last_cyc + int'(PERIOD)) begin
        checks++;
        if (sending !== 1'b1 || tx_data_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_send_start edge=%0d sending=%b valid=%b expected 1/0", e, sending, tx_data_valid);
        end
      end else if (e == last_cyc + int'(PERIOD) + 1) begin
        checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[0]) begin
          errors++;
          $display("FAIL rnd_first edge=%0d valid=%b data=%h expected 1/%h", e, tx_data_valid, tx_data, exp_msg[0]);
        end
      end
      checks++;
      if (rx_data_ready !== 1'b1 || fifo_level !== '0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL rnd_rx edge=%0d ready=%b level=%0d overflow=%b expected 1/0/0", e, rx_data_ready, fifo_level, overflow);
      end
      prev_vld = tx_data_valid;
      prev_dat = tx_data;
      tx_data_ready = ($urandom_range(0, 2) != 0);
      prev_rdy = tx_data_ready;
`ifndef UART_BEACON_ECHO_EN
      rx_data_valid = ($urandom_range(0, 3) == 0);
      rx_data = 8'($urandom);
`endif
    end
    rx_data_valid = 1'b0;
    checks++;
    if (msgs < 5) begin
      errors++;
      $display("FAIL rnd_progress messages=%0d expected at least 5", msgs);
    end
  endtask

`ifdef UART_BEACON_ECHO_EN
  task automatic test_echo();
    logic [7:0] got [$];
    logic [7:0] exp [$];
    logic       pv;
    logic [7:0] pd;
    hold_reset();
    tx_data_ready = 1'b1;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    rx_data = 8'h31;
    rx_data_valid = 1'b1;
    tick();
    rx_data = 8'h32;
    tick();
    rx_data_valid = 1'b0;
    checks++;
    if (fifo_level !== LW'(2) || sending !== 1'b1) begin
      errors++;
      $display("FAIL echo_level level=%0d sending=%b expected 2/1", fifo_level, sending);
    end
    exp = '{exp_msg[1], exp_msg[2], 8'h31, 8'h32};
    pv = tx_data_valid;
    pd = tx_data;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pv) got.push_back(pd);
      pv = tx_data_valid;
      pd = tx_data;
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL echo_count got=%0d expected=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL echo_byte%0d got=%h expected=%h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (fifo_level !== '0) begin
      errors++;
      $display("FAIL echo_drain level=%0d expected 0", fifo_level);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got [$];
    logic [7:0] exp [$];
    logic [7:0] b;
    logic       pv;
    logic [7:0] pd;
    hold_reset();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    exp = '{exp_msg[0], exp_msg[1], exp_msg[2]};
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) exp.push_back(b);
      rx_data = b;
      rx_data_valid = 1'b1;
      tick();
      checks++;
      if (rx_data_ready !== (i < DEPTH - 1) || fifo_level !== LW'((i < DEPTH) ? i + 1 : DEPTH)) begin
        errors++;
        $display("FAIL ovf_fill%0d ready=%b level=%0d", i, rx_data_ready, fifo_level);
      end
    end
    rx_data_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag overflow=%b expected 1", overflow);
    end
    tx_data_ready = 1'b1;
    pv = tx_data_valid;
    pd = tx_data;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (pv) got.push_back(pd);
      pv = tx_data_valid;
      pd = tx_data;
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL ovf_count got=%0d expected=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL ovf_byte%0d got=%h expected=%h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_level !== '0 || rx_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after overflow=%b level=%0d ready=%b expected 1/0/1", overflow, fifo_level, rx_data_ready);
    end
  endtask

  task automatic test_echo_expiry();
    logic [7:0] x;
    logic [7:0] y;
    logic       found;
    x = 8'h60 + 8'($urandom_range(0, 15));
    y = 8'h70 + 8'($urandom_range(0, 15));
    found = 1'b0;
    hold_reset();
    tx_data_ready = 1'b1;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (11) tick();
    rx_data = x;
    rx_data_valid = 1'b1;
    tx_data_ready = 1'b0;
    tick();
    rx_data = y;
    tick();
    rx_data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== x || sending !== 1'b0) begin
        errors++;
        $display("FAIL exp_hold%0d valid=%b data=%h sending=%b expected 1/%h/0", i, tx_data_valid, tx_data, sending, x);
      end
      if (i < 3) tick();
    end
    tx_data_ready = 1'b1;
    tick();
    checks++;
    if (tx_data_valid !== 1'b0 || sending !== 1'b0 || fifo_level !== LW'(1)) begin
      errors++;
      $display("FAIL exp_done valid=%b sending=%b level=%0d expected 0/0/1", tx_data_valid, sending, fifo_level);
    end
    tick();
    checks++;
    if (sending !== 1'b1 || tx_data_valid !== 1'b0 || fifo_level !== LW'(1)) begin
      errors++;
      $display("FAIL exp_send sending=%b valid=%b level=%0d expected 1/0/1", sending, tx_data_valid, fifo_level);
    end
    tick();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== exp_msg[0]) begin
      errors++;
      $display("FAIL exp_first valid=%b data=%h expected 1/%h", tx_data_valid, tx_data, exp_msg[0]);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_data_valid && !sending && tx_data == y) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL exp_later_echo byte %h not echoed after next message", y);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_message();
    test_period();
    test_stall();
    test_reset_mid_byte();
    test_random_throttle();
`ifdef UART_BEACON_ECHO_EN
    test_echo();
    test_overflow();
    test_echo_expiry();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_beacon_echo.md
UART_BEACON_ECHO -- requirements
Module: uart_beacon_echo

Interface
REQ-001 SHALL have parameter MSG_LEN, default 21: message length in bytes, legal range 1..255.
REQ-002 SHALL have parameter MSG, default "Hello Tang Nano 20K" followed by 0x0D 0x0A: MSG_LEN*8 bits, first byte in the most significant bits.
REQ-003 SHALL have parameter PERIOD_CYCLES, default 27_000_000: WAIT duration in clocks, legal range 1..2^32-1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: echo FIFO depth, a power of 2, legal range 2..256.
REQ-005 Port: sys_clk  in  1  sole clock, rising edge.
REQ-006 Port: sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 Port: rx_data  in  8  received byte from the UART receiver.
REQ-008 Port: rx_data_valid  in  1  rx_data valid, one-cycle pulse.
REQ-009 Port: rx_data_ready  out  1  high when a byte can be accepted (FIFO not full).
REQ-010 Port: tx_data  out  8  byte to the UART transmitter, registered.
REQ-011 Port: tx_data_valid  out  1  tx_data valid, registered.
REQ-012 Port: tx_data_ready  in  1  transmitter accepts the byte this cycle.
REQ-013 Port: fifo_level  out  $clog2(FIFO_DEPTH)+1  current echo FIFO occupancy.
REQ-014 Port: overflow  out  1  sticky flag: a received byte was dropped.
REQ-015 Port: sending  out  1  high while state is SEND.

Function
REQ-016 Handshake: a byte SHALL transfer on a cycle where tx_data_valid && tx_data_ready; once tx_data_valid is high, tx_data and tx_data_valid SHALL hold until that transfer.
REQ-017 States: IDLE, SEND, WAIT; IDLE SHALL go to SEND on the first clock after reset release.
REQ-018 SEND entry SHALL reset byte index k to 0; tx_data_valid SHALL rise one clock after entering SEND, with tx_data = MSG byte k.
REQ-019 In SEND, each transfer SHALL increment k and present the next byte with valid kept high, giving back-to-back bytes with no bubble.
REQ-020 Transfer of byte MSG_LEN-1 SHALL drop tx_data_valid, clear the period counter to 0 and enter WAIT on the same edge.
REQ-021 In WAIT, the period counter SHALL increment by 1 each clock and saturate at PERIOD_CYCLES-1.
REQ-022 In WAIT, when tx_data_valid is low and the FIFO is not empty, the next clock SHALL pop the FIFO head into tx_data and raise tx_data_valid.
REQ-023 In WAIT, an echo transfer SHALL drop tx_data_valid; a new echo byte SHALL be presented no earlier than the following clock.
REQ-024 WAIT SHALL go to SEND when the counter equals PERIOD_CYCLES-1 and tx_data_valid is low; an echo byte in flight SHALL complete first, and the FIFO SHALL NOT be popped on that exit cycle.
REQ-025 The FIFO SHALL push rx_data when rx_data_valid && rx_data_ready, in every state including SEND.
REQ-026 rx_data_ready SHALL equal !full combinationally from registered FIFO state.
REQ-027 rx_data_valid while full SHALL drop the byte and set overflow; overflow SHALL clear only on reset.
REQ-028 A push and a pop in the same cycle SHALL leave fifo_level unchanged, including when the FIFO is full.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly FIFO.

Reset
REQ-030 Reset assertion SHALL asynchronously force: state IDLE, tx_data 0, tx_data_valid 0, k 0, counter 0, FIFO empty, fifo_level 0, overflow 0, sending 0, rx_data_ready 1.
REQ-031 Reset mid-byte SHALL abandon the handshake; after release the sequence SHALL restart with MSG byte 0.

Configuration
REQ-032 Macro UART_BEACON_ECHO_EN defined: the echo FIFO and REQ-022..REQ-029 SHALL be present.
REQ-033 Macro UART_BEACON_ECHO_EN undefined: no FIFO; rx_data_ready tied 1; received bytes discarded; fifo_level and overflow tied 0; WAIT exits purely on the counter.

Structure
REQ-034 Package uart_pkg SHALL hold the state encoding, default PERIOD_CYCLES, and the byte width constant 8.
REQ-035 The echo FIFO SHALL be sub-module uart_byte_fifo (parameter DEPTH; push/pop/full/empty/level ports), instantiated only under UART_BEACON_ECHO_EN.

Verification
REQ-036 MSG_LEN=3, MSG="ABC", tx_data_ready tied 1 -> 0x41, 0x42, 0x43 on consecutive clocks; valid first high 2 clocks after reset release.
REQ-037 tx_data_ready low for 5 clocks mid-message -> tx_data and tx_data_valid stable for those 5 clocks, no byte skipped.
REQ-038 PERIOD_CYCLES=10, no rx -> next SEND starts exactly 10 clocks after the last message transfer.
REQ-039 During SEND, push 0x31 then 0x32 -> after SEND, 0x31 then 0x32 echoed in WAIT; fifo_level returns to 0.
REQ-040 FIFO_DEPTH=4, tx_data_ready low, 5 rx bytes -> rx_data_ready low after the 4th, overflow=1, bytes 1-4 echoed in order.
REQ-041 Echo byte in flight at counter expiry, tx_data_ready released 3 clocks later -> echo completes, then SEND starts with MSG byte 0.
